// File: rtl/ex_mdu_sequencer.sv
// Iterative multiply/divide sequencer beside the EX-stage ALU. It owns HI/LO,
// runs 32-step shift-add multiply or restoring divide, and stalls IF/ID/EX meanwhile.
module ex_mdu_sequencer #(
  parameter int                   NB_DATA   = 32,
  parameter int                   NB_FUNCT  = 6,
  parameter int                   NB_ALU_OP = 4,
  parameter logic [NB_ALU_OP-1:0] R_TYPE_OP = 4'b0010
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [NB_ALU_OP-1:0] i_alu_op_CU,
  input  logic [NB_FUNCT-1:0]  i_funct,
  input  logic [NB_DATA-1:0]   i_rs_data,
  input  logic [NB_DATA-1:0]   i_rt_data,
  input  logic                 i_flush,
  output logic                 o_stall,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_hilo_sel,
  output logic [NB_DATA-1:0]   o_hilo_data,
  output logic [NB_DATA-1:0]   o_hi,
  output logic [NB_DATA-1:0]   o_lo
);

  localparam int CNT_W = $clog2(NB_DATA);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NB_DATA - 1);

  localparam logic [NB_FUNCT-1:0] F_MFHI  = 6'b010000;
  localparam logic [NB_FUNCT-1:0] F_MTHI  = 6'b010001;
  localparam logic [NB_FUNCT-1:0] F_MFLO  = 6'b010010;
  localparam logic [NB_FUNCT-1:0] F_MTLO  = 6'b010011;
  localparam logic [NB_FUNCT-1:0] F_MULT  = 6'b011000;
  localparam logic [NB_FUNCT-1:0] F_MULTU = 6'b011001;
  localparam logic [NB_FUNCT-1:0] F_DIV   = 6'b011010;
  localparam logic [NB_FUNCT-1:0] F_DIVU  = 6'b011011;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*NB_DATA-1:0]   acc_q, acc_d;
  logic [NB_DATA-1:0]     opnd_q, opnd_d;
  logic                   is_div_q, is_div_d;
  logic                   neg_res_q, neg_res_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [NB_DATA-1:0]     hi_q, hi_d;
  logic [NB_DATA-1:0]     lo_q, lo_d;
  logic                   done_q, done_d;

  logic dec_ok, dec_mul, dec_div, dec_signed;
  logic dec_mthi, dec_mtlo, dec_mfhi, dec_mflo;
  logic [NB_DATA-1:0] mag_rs, mag_rt;

  assign dec_ok     = i_valid & (i_alu_op_CU == R_TYPE_OP) & ~i_flush;
  assign dec_mul    = dec_ok & ((i_funct == F_MULT) | (i_funct == F_MULTU));
  assign dec_div    = dec_ok & ((i_funct == F_DIV)  | (i_funct == F_DIVU));
  assign dec_signed = (i_funct == F_MULT) | (i_funct == F_DIV);
  assign dec_mthi   = dec_ok & (i_funct == F_MTHI);
  assign dec_mtlo   = dec_ok & (i_funct == F_MTLO);
  assign dec_mfhi   = dec_ok & (i_funct == F_MFHI);
  assign dec_mflo   = dec_ok & (i_funct == F_MFLO);

  // 0x80000000 negates to itself, which is its correct unsigned magnitude.
  assign mag_rs = (dec_signed & i_rs_data[NB_DATA-1]) ? -i_rs_data : i_rs_data;
  assign mag_rt = (dec_signed & i_rt_data[NB_DATA-1]) ? -i_rt_data : i_rt_data;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  logic [NB_DATA:0]     mul_sum;
  logic [2*NB_DATA-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(NB_DATA+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[NB_DATA-1:1]};

  // Divide: acc = {remainder, dividend bits / quotient bits}, shifted left.
  logic [NB_DATA:0]     div_top, div_trial;
  logic                 div_ok;
  logic [NB_DATA-1:0]   div_rem;
  logic [2*NB_DATA-1:0] div_next;
  assign div_top   = acc_q[2*NB_DATA-1:NB_DATA-1];
  assign div_trial = div_top - {1'b0, opnd_q};
  assign div_ok    = ~div_trial[NB_DATA];
  assign div_rem   = div_ok ? div_trial[NB_DATA-1:0] : div_top[NB_DATA-1:0];
  assign div_next  = {div_rem, acc_q[NB_DATA-2:0], div_ok};

  logic [2*NB_DATA-1:0] step, prod;
  logic [NB_DATA-1:0]   quot, rem;
  logic                 div_zero;
  assign step     = is_div_q ? div_next : mul_next;
  assign prod     = neg_res_q ? -step : step;
  assign quot     = step[NB_DATA-1:0];
  assign rem      = step[2*NB_DATA-1:NB_DATA];
  assign div_zero = (opnd_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    o_stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dec_mul | dec_div) begin
          o_stall   = 1'b1;
          state_d   = BUSY;
          cnt_d     = '0;
          is_div_d  = dec_div;
          neg_res_d = dec_signed & (i_rs_data[NB_DATA-1] ^ i_rt_data[NB_DATA-1]);
          neg_rem_d = dec_signed & i_rs_data[NB_DATA-1];
          if (dec_div) begin
            acc_d  = {{NB_DATA{1'b0}}, mag_rs};
            opnd_d = mag_rt;
          end else begin
            acc_d  = {{NB_DATA{1'b0}}, mag_rt};
            opnd_d = mag_rs;
          end
        end else begin
          if (dec_mthi) hi_d = i_rs_data;
          if (dec_mtlo) lo_d = i_rs_data;
        end
      end
      BUSY: begin
        if (i_flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
              // Divide by zero leaves all-ones quotient and the latched dividend.
              lo_d = (neg_res_q & ~div_zero) ? -quot : quot;
              hi_d = (neg_rem_q & ~div_zero) ? -rem  : rem;
            end else begin
              {hi_d, lo_d} = prod;
            end
          end else begin
            o_stall = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign o_busy      = (state_q == BUSY);
  assign o_done      = done_q;
  assign o_hilo_sel  = dec_mfhi | dec_mflo;
  assign o_hilo_data = dec_mfhi ? hi_q : (dec_mflo ? lo_q : '0);
  assign o_hi        = hi_q;
  assign o_lo        = lo_q;

endmodule
